oram_req_frontend: RTL and testbench

Request front-end that sits directly upstream of `oram_module`. It accepts client read/write requests on a valid/ready interface and buffers them in a small FIFO. It issues them one at a time to the ORAM core using the core's `block_num`/`write_val`/`rw_indicator`/`input_ready` handshake, including the per-request core reset pulse the core requires. It then returns each result on a held valid/ready response channel.

---
 rtl/oram_req_frontend_pkg.sv | 14 +
 rtl/oram_req_frontend_fifo.sv | 49 ++++
 rtl/oram_req_frontend.sv | 138 +++++++++++++
 tb/tb_oram_req_frontend.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/oram_req_frontend_pkg.sv
// Shared ORAM geometry plus the request-frontend types (request record and FSM encoding).
package oramPkg;
  localparam int d           = 4;
  localparam int a           = 1;
  localparam int ORAM_DATA_W = 8 * a;

  typedef struct packed {
    logic                   rw;
    logic [d-1:0]           block;
    logic [ORAM_DATA_W-1:0] data;
  } oram_req_t;

  typedef enum logic [1:0] {FE_IDLE, FE_PREP, FE_ISSUE, FE_RESP} oram_fe_state_t;
endpackage

// File: rtl/oram_req_frontend_fifo.sv
// Registered request FIFO; head is the oldest entry, valid whenever empty is low.
module oram_req_fifo
  import oramPkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  oram_req_t push_data,
  input  logic      pop,
  output logic      full,
  output logic      empty,
  output oram_req_t head
);
  localparam int PW = $clog2(DEPTH);

  oram_req_t     mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [PW:0]   count_reg;
  logic          do_push, do_pop;

  // A push is refused when full even if a pop happens in the same cycle.
  assign full    = (count_reg == (PW + 1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr_reg];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (PW + 1)'(1);
        2'b01:   count_reg <= count_reg - (PW + 1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end
endmodule

// File: rtl/oram_req_frontend.sv
// Client-facing request queue that serialises requests onto the oram_module handshake.
// Optional ORAM_FE_STATS_EN adds saturating read/write completion counters.
module oram_req_frontend
  import oramPkg::*;
#(
  parameter int REQ_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_rw,
  input  logic [d-1:0]           req_block,
  input  logic [ORAM_DATA_W-1:0] req_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic                   rsp_rw,
  output logic [d-1:0]           rsp_block,
  output logic [ORAM_DATA_W-1:0] rsp_rdata,
  output logic                   core_rst,
  output logic [d-1:0]           core_block_num,
  output logic [ORAM_DATA_W-1:0] core_write_val,
  output logic                   core_rw_indicator,
  output logic                   core_input_ready,
  input  logic [ORAM_DATA_W-1:0] core_read_val,
  input  logic                   core_output_ready
`ifdef ORAM_FE_STATS_EN
  ,
  output logic [15:0]            stat_rd_cnt,
  output logic [15:0]            stat_wr_cnt
`endif
);
  oram_fe_state_t         state_reg, state_next;
  oram_req_t              issue_reg, fifo_head, push_req;
  logic                   live_reg;
  logic                   fifo_full, fifo_empty, fifo_push, fifo_pop, rsp_load;
  logic                   rsp_rw_reg;
  logic [d-1:0]           rsp_block_reg;
  logic [ORAM_DATA_W-1:0] rsp_rdata_reg;

  assign push_req  = '{rw: req_rw, block: req_block, data: req_wdata};
  // live_reg keeps req_ready low and core_rst high until the first edge after reset release.
  assign req_ready = live_reg && !fifo_full;
  assign fifo_push = req_valid && req_ready;

  oram_req_fifo #(.DEPTH(REQ_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (push_req),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  always_comb begin
    state_next = state_reg;
    fifo_pop   = 1'b0;
    rsp_load   = 1'b0;
    case (state_reg)
      FE_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          state_next = FE_PREP;
        end
      end
      FE_PREP:  state_next = FE_ISSUE;
      FE_ISSUE: begin
        if (core_output_ready) begin
          rsp_load   = 1'b1;
          state_next = FE_RESP;
        end
      end
      FE_RESP: begin
        if (rsp_ready) begin
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            state_next = FE_PREP;
          end else begin
            state_next = FE_IDLE;
          end
        end
      end
      default: state_next = FE_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= FE_IDLE;
      live_reg      <= 1'b0;
      issue_reg     <= '0;
      rsp_rw_reg    <= 1'b0;
      rsp_block_reg <= '0;
      rsp_rdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      live_reg  <= 1'b1;
      if (fifo_pop) issue_reg <= fifo_head;
      if (rsp_load) begin
        rsp_rw_reg    <= issue_reg.rw;
        rsp_block_reg <= issue_reg.block;
        rsp_rdata_reg <= issue_reg.rw ? '0 : core_read_val;
      end
    end
  end

  assign rsp_valid         = (state_reg == FE_RESP);
  assign rsp_rw            = rsp_rw_reg;
  assign rsp_block         = rsp_block_reg;
  assign rsp_rdata         = rsp_rdata_reg;
  assign core_rst          = !live_reg || (state_reg == FE_PREP);
  assign core_input_ready  = (state_reg == FE_ISSUE);
  assign core_block_num    = issue_reg.block;
  assign core_write_val    = issue_reg.data;
  assign core_rw_indicator = issue_reg.rw;

`ifdef ORAM_FE_STATS_EN
  logic [15:0] stat_rd_reg, stat_wr_reg;
  logic        rsp_done;

  assign rsp_done = (state_reg == FE_RESP) && rsp_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_rd_reg <= '0;
      stat_wr_reg <= '0;
    end else if (rsp_done) begin
      if (rsp_rw_reg && stat_wr_reg != 16'hFFFF)  stat_wr_reg <= stat_wr_reg + 16'd1;
      if (!rsp_rw_reg && stat_rd_reg != 16'hFFFF) stat_rd_reg <= stat_rd_reg + 16'd1;
    end
  end

  assign stat_rd_cnt = stat_rd_reg;
  assign stat_wr_cnt = stat_wr_reg;
`endif
endmodule

// File: tb/tb_oram_req_frontend.sv
// Directed bench for oram_req_frontend with a behavioural oram_module stand-in.
module tb_oram_req_frontend;
  import oramPkg::*;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic                   req_valid = 1'b0;
  logic                   req_ready;
  logic                   req_rw = 1'b0;
  logic [d-1:0]           req_block = '0;
  logic [ORAM_DATA_W-1:0] req_wdata = '0;
  logic                   rsp_valid;
  logic                   rsp_ready = 1'b0;
  logic                   rsp_rw;
  logic [d-1:0]           rsp_block;
  logic [ORAM_DATA_W-1:0] rsp_rdata;
  logic                   core_rst;
  logic [d-1:0]           core_block_num;
  logic [ORAM_DATA_W-1:0] core_write_val;
  logic                   core_rw_indicator;
  logic                   core_input_ready;
  logic [ORAM_DATA_W-1:0] core_read_val = '0;
  logic                   core_output_ready = 1'b0;
`ifdef ORAM_FE_STATS_EN
  logic [15:0]            stat_rd_cnt, stat_wr_cnt;
`endif

  oram_req_frontend #(.REQ_DEPTH(4)) dut (
    .clk               (clk),
    .rst               (rst),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_rw            (req_rw),
    .req_block         (req_block),
    .req_wdata         (req_wdata),
    .rsp_valid         (rsp_valid),
    .rsp_ready         (rsp_ready),
    .rsp_rw            (rsp_rw),
    .rsp_block         (rsp_block),
    .rsp_rdata         (rsp_rdata),
    .core_rst          (core_rst),
    .core_block_num    (core_block_num),
    .core_write_val    (core_write_val),
    .core_rw_indicator (core_rw_indicator),
    .core_input_ready  (core_input_ready),
    .core_read_val     (core_read_val),
    .core_output_ready (core_output_ready)
`ifdef ORAM_FE_STATS_EN
    ,
    .stat_rd_cnt       (stat_rd_cnt),
    .stat_wr_cnt       (stat_wr_cnt)
`endif
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("[TB] ok %s = %0h", tag, got);
    end
  endtask

  // Core stand-in: answers after core_delay extra ISSUE cycles, returns the old block value.
  logic [ORAM_DATA_W-1:0] core_mem [16];
  int core_delay = 0;
  int core_wait  = 0;
  initial for (int i = 0; i < 16; i++) core_mem[i] = '0;

  always @(negedge clk) begin
    if (!core_input_ready) begin
      core_output_ready = 1'b0;
      core_wait = 0;
    end else if (!core_output_ready) begin
      if (core_wait >= core_delay) begin
        core_output_ready = 1'b1;
        core_read_val = core_mem[core_block_num];
        if (core_rw_indicator) core_mem[core_block_num] = core_write_val;
      end else begin
        core_wait++;
      end
    end
  end

  // Issue monitor: PREP length before each issue, ISSUE length and field stability.
  int   rst_run = 0, last_prep_len = 0, issue_cnt = 0, ir_len = 0, last_ir_len = 0, unstable = 0;
  logic prev_ir = 1'b0;
  logic [12:0] issue_fields = '0;

  always @(negedge clk) begin
    if (core_input_ready && !prev_ir) begin
      last_prep_len = rst_run;
      issue_cnt++;
      issue_fields = {core_rw_indicator, core_block_num, core_write_val};
      ir_len = 0;
    end
    if (core_input_ready) begin
      ir_len++;
      if ({core_rw_indicator, core_block_num, core_write_val} !== issue_fields) unstable++;
    end
    if (!core_input_ready && prev_ir) last_ir_len = ir_len;
    rst_run = core_rst ? rst_run + 1 : 0;
    prev_ir = core_input_ready;
  end

  task automatic push_req(input logic rw, input logic [d-1:0] blk, input logic [ORAM_DATA_W-1:0] data);
    int n = 0;
    req_rw = rw;
    req_block = blk;
    req_wdata = data;
    req_valid = 1'b1;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("push_timeout", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic get_rsp(input string tag, input logic rw, input logic [d-1:0] blk,
                         input logic [ORAM_DATA_W-1:0] data, output int lat);
    int n = 0;
    while (!rsp_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    lat = n;
    check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, "_rw"}, 32'(rsp_rw), 32'(rw));
    check({tag, "_block"}, 32'(rsp_block), 32'(blk));
    check({tag, "_rdata"}, 32'(rsp_rdata), 32'(data));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int snap;
    int vcnt;
    logic [d-1:0] held_block;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_core_rst", 32'(core_rst), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_core_ir", 32'(core_input_ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("rel_req_ready", 32'(req_ready), 32'd1);
    check("rel_core_rst", 32'(core_rst), 32'd0);

    // Single write then read, minimum latency
    push_req(1'b1, 4'd1, 8'd2);
    get_rsp("wr1", 1'b1, 4'd1, 8'd0, lat);
    check("wr1_latency", 32'(lat), 32'd3);
    push_req(1'b0, 4'd1, 8'd0);
    get_rsp("rd1", 1'b0, 4'd1, 8'd2, lat);
    check("rd1_latency", 32'(lat), 32'd3);

    // Back-to-back pushes, one core_rst cycle ahead of each issue
    push_req(1'b1, 4'd1, 8'd2);
    push_req(1'b1, 4'd3, 8'd10);
    push_req(1'b0, 4'd3, 8'd0);
    get_rsp("b2b_w1", 1'b1, 4'd1, 8'd0, lat);
    check("b2b_prep1", 32'(last_prep_len), 32'd1);
    get_rsp("b2b_w3", 1'b1, 4'd3, 8'd0, lat);
    check("b2b_prep2", 32'(last_prep_len), 32'd1);
    get_rsp("b2b_r3", 1'b0, 4'd3, 8'd10, lat);
    check("b2b_prep3", 32'(last_prep_len), 32'd1);

    // Backpressure: five requests against a four-deep FIFO
    push_req(1'b1, 4'd5, 8'h55);
    push_req(1'b1, 4'd6, 8'h66);
    push_req(1'b0, 4'd5, 8'h00);
    push_req(1'b0, 4'd3, 8'h00);
    push_req(1'b1, 4'd3, 8'h77);
    check("bp_req_ready_full", 32'(req_ready), 32'd0);
    check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    held_block = rsp_block;
    repeat (5) @(negedge clk);
    check("bp_stall_valid", 32'(rsp_valid), 32'd1);
    check("bp_stall_block", 32'(rsp_block), 32'(held_block));
    check("bp_stall_rdata", 32'(rsp_rdata), 32'd0);
    get_rsp("bp_w5", 1'b1, 4'd5, 8'h00, lat);
    check("bp_req_ready_free", 32'(req_ready), 32'd1);
    get_rsp("bp_w6", 1'b1, 4'd6, 8'h00, lat);
    get_rsp("bp_r5", 1'b0, 4'd5, 8'h55, lat);
    get_rsp("bp_r3", 1'b0, 4'd3, 8'd10, lat);
    get_rsp("bp_w3", 1'b1, 4'd3, 8'h00, lat);

    // Slow core: 20 extra cycles before output_ready
    core_delay = 20;
    push_req(1'b0, 4'd1, 8'h00);
    get_rsp("slow_r1", 1'b0, 4'd1, 8'd2, lat);
    check("slow_latency", 32'(lat), 32'd23);
    check("slow_ir_len", 32'(last_ir_len), 32'd21);
    check("slow_stable", 32'(unstable), 32'd0);
    core_delay = 0;

    // Reset mid-ISSUE with two entries queued
    core_delay = 50;
    push_req(1'b1, 4'd7, 8'h99);
    push_req(1'b0, 4'd7, 8'h00);
    push_req(1'b0, 4'd1, 8'h00);
    vcnt = 0;
    while (!core_input_ready && vcnt < 50) begin
      @(negedge clk);
      vcnt++;
    end
    check("mid_in_issue", 32'(core_input_ready), 32'd1);
    check("mid_issue_block", 32'(core_block_num), 32'd7);
    rst = 1'b0;
    #1;
    check("mid_rst_req_ready", 32'(req_ready), 32'd0);
    check("mid_rst_core_rst", 32'(core_rst), 32'd1);
    check("mid_rst_core_ir", 32'(core_input_ready), 32'd0);
    check("mid_rst_core_block", 32'(core_block_num), 32'd0);
    check("mid_rst_core_wval", 32'(core_write_val), 32'd0);
    check("mid_rst_core_rw", 32'(core_rw_indicator), 32'd0);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_rsp_fields", 32'({rsp_rw, rsp_block, rsp_rdata}), 32'd0);
    repeat (2) @(negedge clk);
    core_delay = 0;
    snap = issue_cnt;
    rst = 1'b1;
    @(negedge clk);
    check("mid_rel_req_ready", 32'(req_ready), 32'd1);
    check("mid_rel_core_rst", 32'(core_rst), 32'd0);
    rsp_ready = 1'b1;
    vcnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (rsp_valid) vcnt++;
    end
    rsp_ready = 1'b0;
    check("mid_no_rsp", 32'(vcnt), 32'd0);
    check("mid_no_issue", 32'(issue_cnt - snap), 32'd0);
    check("mid_wr_dropped", 32'(core_mem[7]), 32'd0);
    push_req(1'b0, 4'd1, 8'h00);
    get_rsp("post_r1", 1'b0, 4'd1, 8'd2, lat);

`ifdef ORAM_FE_STATS_EN
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("stat_rd_rst", 32'(stat_rd_cnt), 32'd0);
    check("stat_wr_rst", 32'(stat_wr_cnt), 32'd0);
    push_req(1'b0, 4'd1, 8'h00);
    push_req(1'b1, 4'd2, 8'h21);
    push_req(1'b0, 4'd2, 8'h00);
    push_req(1'b1, 4'd4, 8'h41);
    push_req(1'b0, 4'd4, 8'h00);
    get_rsp("st_r1", 1'b0, 4'd1, 8'd2, lat);
    get_rsp("st_w2", 1'b1, 4'd2, 8'd0, lat);
    get_rsp("st_r2", 1'b0, 4'd2, 8'h21, lat);
    get_rsp("st_w4", 1'b1, 4'd4, 8'd0, lat);
    get_rsp("st_r4", 1'b0, 4'd4, 8'h41, lat);
    check("stat_rd_cnt", 32'(stat_rd_cnt), 32'd3);
    check("stat_wr_cnt", 32'(stat_wr_cnt), 32'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
